// File: rtl/udp_tx_pkg.sv
// Shared types and helpers for the UDP packet serializer.
// Holds the FSM state encoding, header geometry and the
// ones-complement arithmetic used by the checksum accumulator.
package udp_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FINAL = 3'd3,
        ST_START = 3'd4,
        ST_SHIFT = 3'd5,
        ST_GAP   = 3'd6
    } tx_state_e;

    // Minimum legal packet: the 8-byte UDP header.
    localparam int UDP_HDR_BYTES = 8;
    // Byte offset of the 16-bit checksum field inside the header.
    localparam int CSUM_OFFSET   = 6;

    // 16-bit ones-complement addition (end-around carry).
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    // Final checksum: complement of the sum, with 0x0000 sent as 0xFFFF.
    function automatic logic [15:0] csum_final(input logic [15:0] sum);
        return (sum == 16'hFFFF) ? 16'hFFFF : ~sum;
    endfunction

endpackage

// File: rtl/udp_packet_tx_if.sv
// Byte-stream input handshake of the UDP packet serializer.
// The upstream (master) holds i_data/i_last while i_valid is high
// until o_ready is seen high on a clock edge.
interface udp_packet_tx_if;
    logic [7:0] i_data;
    logic       i_valid;
    logic       i_last;
    logic       o_ready;

    modport master (output i_data, output i_valid, output i_last, input o_ready);
    modport slave  (input i_data, input i_valid, input i_last, output o_ready);
endinterface

// File: rtl/udp_csum_acc.sv
// UDP checksum accumulator: 16-bit ones-complement running sum with
// end-around carry, plus the final complement (zero sent as 0xFFFF).
// Only instantiated when UDP_TX_CSUM_EN is defined.
module udp_csum_acc
    import udp_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        add_en,
    input  logic [15:0] word,
    output logic [15:0] csum
);

    logic [15:0] sum_r;

    // Running sum: cleared at the first byte of a packet, folded per word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r <= 16'h0000;
        end else if (clr) begin
            sum_r <= 16'h0000;
        end else if (add_en) begin
            sum_r <= ones_add(sum_r, word);
        end else begin
            sum_r <= sum_r;
        end
    end

    assign csum = csum_final(sum_r);

endmodule

// File: rtl/udp_packet_tx.sv
// UDP packet serializer: buffers one packet (header + payload),
// computes the UDP checksum on the fly, then sends a start bit, each
// byte MSB first with a low spacer cycle, and a low inter-packet gap.
// Short packets (< 8 bytes) and oversize packets are dropped with an
// o_error pulse.
// Optional feature macro: UDP_TX_CSUM_EN (checksum computation and
// insertion). Without it the checksum field is sent as 0x0000.
module udp_packet_tx
    import udp_tx_pkg::*;
#(
    parameter int MAX_BYTES  = 64,
    parameter int GAP_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    udp_packet_tx_if.slave    in_bus,
    output logic              o_serial,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [15:0]       o_csum
);

    localparam int CW = $clog2(MAX_BYTES + 1);
    localparam int AW = $clog2(MAX_BYTES);
    localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES);
    localparam logic [CW-1:0] HDR_CNT = CW'(UDP_HDR_BYTES);
    localparam logic [CW-1:0] CSUM_HI = CW'(CSUM_OFFSET);
    localparam logic [CW-1:0] CSUM_LO = CW'(CSUM_OFFSET + 1);
    localparam logic [GW-1:0] GAP_CNT = GW'(GAP_CYCLES);

    tx_state_e      state_r;
    logic [CW-1:0]  count_r;
    logic [CW-1:0]  byte_idx_r;
    logic [3:0]     bit_idx_r;
    logic [GW-1:0]  gap_cnt_r;

    logic [7:0]     mem [MAX_BYTES];

    logic           ready_s;
    logic           accept_s;
    logic           buf_wr_s;
    logic [AW-1:0]  wr_addr_s;
    logic [CW-1:0]  cnt_inc_s;
    logic [CW-1:0]  last_idx_s;
    logic [CW-1:0]  rd_idx_s;
    logic [2:0]     rd_bit_s;
    logic [7:0]     rd_byte_s;
    logic [7:0]     tx_byte_s;
    logic           tx_bit_s;
    logic [15:0]    csum_s;

    assign ready_s        = (state_r == ST_IDLE) || (state_r == ST_FILL) || (state_r == ST_DRAIN);
    assign in_bus.o_ready = ready_s;
    assign accept_s       = in_bus.i_valid && ready_s;
    assign cnt_inc_s      = count_r + CW'(1);
    assign last_idx_s     = count_r - CW'(1);

    // Buffer write qualification: first byte in IDLE, later bytes in FILL while room remains.
    always_comb begin
        buf_wr_s  = 1'b0;
        wr_addr_s = '0;
        if (accept_s && (state_r == ST_IDLE)) begin
            buf_wr_s  = 1'b1;
            wr_addr_s = '0;
        end else if (accept_s && (state_r == ST_FILL) && (count_r != MAX_CNT)) begin
            buf_wr_s  = 1'b1;
            wr_addr_s = count_r[AW-1:0];
        end else begin
            buf_wr_s  = 1'b0;
        end
    end

    // Packet buffer write port; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (buf_wr_s) begin
            mem[wr_addr_s] <= in_bus.i_data;
        end
    end

    // Select the byte/bit that the serial line shows in the next cycle.
    always_comb begin
        rd_idx_s = byte_idx_r;
        rd_bit_s = 3'd7;
        if (state_r == ST_START) begin
            rd_idx_s = '0;
            rd_bit_s = 3'd7;
        end else if (bit_idx_r == 4'd8) begin
            rd_idx_s = byte_idx_r + CW'(1);
            rd_bit_s = 3'd7;
        end else begin
            rd_idx_s = byte_idx_r;
            rd_bit_s = 3'(4'd6 - bit_idx_r);
        end
        rd_byte_s = mem[rd_idx_s[AW-1:0]];
        if (rd_idx_s == CSUM_HI) begin
            tx_byte_s = o_csum[15:8];
        end else if (rd_idx_s == CSUM_LO) begin
            tx_byte_s = o_csum[7:0];
        end else begin
            tx_byte_s = rd_byte_s;
        end
        tx_bit_s = tx_byte_s[rd_bit_s];
    end

`ifdef UDP_TX_CSUM_EN
    logic [CW-1:0]  csum_idx_s;
    logic [7:0]     byte_m_s;
    logic [7:0]     hi_r;
    logic           acc_clr_s;
    logic           acc_add_s;
    logic [15:0]    acc_word_s;

    // Pair buffered bytes into words; checksum field counts as zero, odd tail padded.
    always_comb begin
        acc_clr_s  = 1'b0;
        acc_add_s  = 1'b0;
        acc_word_s = 16'h0000;
        csum_idx_s = (state_r == ST_IDLE) ? '0 : count_r;
        byte_m_s   = ((csum_idx_s == CSUM_HI) || (csum_idx_s == CSUM_LO)) ? 8'h00 : in_bus.i_data;
        if (buf_wr_s) begin
            acc_clr_s = (state_r == ST_IDLE);
            if (csum_idx_s[0]) begin
                acc_add_s  = 1'b1;
                acc_word_s = {hi_r, byte_m_s};
            end else if (in_bus.i_last) begin
                acc_add_s  = 1'b1;
                acc_word_s = {byte_m_s, 8'h00};
            end else begin
                acc_add_s  = 1'b0;
            end
        end else begin
            acc_clr_s = 1'b0;
        end
    end

    // Hold the even (high) byte until its odd partner arrives.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hi_r <= 8'h00;
        end else if (buf_wr_s && !csum_idx_s[0]) begin
            hi_r <= byte_m_s;
        end else begin
            hi_r <= hi_r;
        end
    end

    udp_csum_acc u_csum_acc (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clr    (acc_clr_s),
        .add_en (acc_add_s),
        .word   (acc_word_s),
        .csum   (csum_s)
    );
`else
    assign csum_s = 16'h0000;
`endif

    // Main FSM; outputs are registered together with the state they belong to.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            count_r    <= '0;
            byte_idx_r <= '0;
            bit_idx_r  <= 4'd0;
            gap_cnt_r  <= '0;
            o_serial   <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
            o_csum     <= 16'h0000;
        end else begin
            o_serial <= 1'b0;
            o_done   <= 1'b0;
            o_error  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        count_r <= CW'(1);
                        if (in_bus.i_last) begin
                            o_error <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_FILL;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (accept_s) begin
                        if (count_r == MAX_CNT) begin
                            if (in_bus.i_last) begin
                                o_error <= 1'b1;
                                state_r <= ST_IDLE;
                            end else begin
                                state_r <= ST_DRAIN;
                            end
                        end else begin
                            count_r <= cnt_inc_s;
                            if (in_bus.i_last && (cnt_inc_s < HDR_CNT)) begin
                                o_error <= 1'b1;
                                state_r <= ST_IDLE;
                            end else if (in_bus.i_last) begin
                                state_r <= ST_FINAL;
                            end else begin
                                state_r <= ST_FILL;
                            end
                        end
                    end else begin
                        state_r <= ST_FILL;
                    end
                end
                ST_DRAIN: begin
                    if (accept_s && in_bus.i_last) begin
                        o_error <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_FINAL: begin
                    o_csum   <= csum_s;
                    o_serial <= 1'b1;
                    o_busy   <= 1'b1;
                    state_r  <= ST_START;
                end
                ST_START: begin
                    o_serial   <= tx_bit_s;
                    byte_idx_r <= '0;
                    bit_idx_r  <= 4'd0;
                    state_r    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bit_idx_r == 4'd8) begin
                        if (byte_idx_r == last_idx_s) begin
                            gap_cnt_r <= GW'(1);
                            o_done    <= (GAP_CNT == GW'(1));
                            state_r   <= ST_GAP;
                        end else begin
                            byte_idx_r <= byte_idx_r + CW'(1);
                            bit_idx_r  <= 4'd0;
                            o_serial   <= tx_bit_s;
                        end
                    end else if (bit_idx_r == 4'd7) begin
                        bit_idx_r <= 4'd8;
                    end else begin
                        bit_idx_r <= bit_idx_r + 4'd1;
                        o_serial  <= tx_bit_s;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_CNT) begin
                        o_busy  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GW'(1);
                        o_done    <= ((gap_cnt_r + GW'(1)) == GAP_CNT);
                    end
                end
                default: begin
                    o_busy  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_packet_tx.sv
// Self-checking bench for udp_packet_tx (MAX_BYTES=16, GAP_CYCLES=2).
// A packet-level reference model derives the checksum and the expected
// serial waveform from the packet bytes; directed and random packets.
`timescale 1ns/1ps
module tb_udp_packet_tx;

    localparam int MAXB = 16;
    localparam int GAP  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        serial, busy, done, err;
    logic [15:0] csum;

    int total = 0;
    int bad   = 0;
    logic [15:0] last_csum = 16'h0000;

    always #5 clk = ~clk;

    udp_packet_tx_if bus ();

    udp_packet_tx #(.MAX_BYTES(MAXB), .GAP_CYCLES(GAP)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .in_bus   (bus),
        .o_serial (serial),
        .o_busy   (busy),
        .o_done   (done),
        .o_error  (err),
        .o_csum   (csum)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference UDP checksum over the packet bytes.
    function automatic logic [15:0] model_csum(input logic [7:0] b[$]);
`ifdef UDP_TX_CSUM_EN
        int unsigned s;
        logic [7:0]  hi, lo;
        logic [15:0] r;
        s = 0;
        for (int i = 0; i < b.size(); i += 2) begin
            hi = (i == 6) ? 8'h00 : b[i];
            lo = (i + 1 >= b.size()) ? 8'h00 : ((i + 1 == 7) ? 8'h00 : b[i + 1]);
            s += {16'd0, hi, lo};
        end
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        r = ~s[15:0];
        return (r == 16'h0000) ? 16'hFFFF : r;
`else
        return (b.size() == 0) ? 16'h0000 : 16'h0000;
`endif
    endfunction

    // Drive a packet byte by byte; returns number of accepted bytes.
    task automatic send_bytes(input logic [7:0] b[$], input bit gaps, output int acc);
        int budget;
        bit stuck;
        acc   = 0;
        stuck = 1'b0;
        for (int i = 0; i < b.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.i_valid = 1'b0;
                    bus.i_data  = 8'($urandom);
                    @(negedge clk);
                end
            end
            bus.i_data  = b[i];
            bus.i_valid = 1'b1;
            bus.i_last  = (i == b.size() - 1);
            budget = 0;
            while (!bus.o_ready && budget < 40) begin
                @(negedge clk);
                budget++;
            end
            if (!bus.o_ready) begin
                check_val("ready_wait", {31'd0, bus.o_ready}, 32'd1);
                stuck = 1'b1;
                break;
            end
            @(posedge clk);
            acc++;
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        if (stuck) @(negedge clk);
    endtask

    // Send a legal packet and compare the whole serial frame against the model.
    task automatic run_good(input logic [7:0] b[$], input string nm);
        logic [7:0]  exp_b[$];
        bit          es[$];
        bit          obits[$];
        logic [15:0] c;
        logic [7:0]  ob;
        int n, acc, L, sbad, bbad, ndone, nerr, done_at, start_at;
        c = model_csum(b);
        n = b.size();
        exp_b = b;
        exp_b[6] = c[15:8];
        exp_b[7] = c[7:0];
        es.push_back(1'b0);
        es.push_back(1'b1);
        foreach (exp_b[i]) begin
            for (int j = 7; j >= 0; j--) es.push_back(exp_b[i][j]);
            es.push_back(1'b0);
        end
        for (int g = 0; g < GAP; g++) es.push_back(1'b0);
        L = es.size();
        sbad = 0; bbad = 0; ndone = 0; nerr = 0; done_at = 0; start_at = 0;
        send_bytes(b, 1'b1, acc);
        check_val({nm, "_accepted"}, acc, n);
        for (int k = 1; k <= L + 1; k++) begin
            if (k <= L) begin
                if (serial !== es[k - 1]) sbad++;
                if (busy !== (k >= 2)) bbad++;
            end else begin
                check_val({nm, "_idle_busy"}, {31'd0, busy}, 32'd0);
                check_val({nm, "_idle_ready"}, {31'd0, bus.o_ready}, 32'd1);
            end
            if (done === 1'b1) begin ndone++; done_at = k; end
            if (err === 1'b1) nerr++;
            if (serial === 1'b1 && start_at == 0) start_at = k;
            if (k >= 3 && k <= 2 + 9 * n) obits.push_back(serial);
            bus.i_valid = (k < L);
            bus.i_data  = 8'($urandom);
            bus.i_last  = 1'($urandom);
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        check_val({nm, "_serial_wave"}, sbad, 0);
        check_val({nm, "_busy_wave"}, bbad, 0);
        check_val({nm, "_start_cycle"}, start_at, 2);
        check_val({nm, "_done_count"}, ndone, 1);
        check_val({nm, "_done_cycle"}, done_at, L);
        check_val({nm, "_error_count"}, nerr, 0);
        check_val({nm, "_csum"}, csum, c);
        for (int i = 0; i < n; i++) begin
            ob = 8'h00;
            for (int j = 0; j < 8; j++) ob = {ob[6:0], obits[9 * i + j]};
            check_val($sformatf("%s_byte%0d", nm, i), ob, exp_b[i]);
        end
        last_csum = c;
    endtask

    // Send an illegal packet; expect one error pulse and a silent line.
    task automatic run_drop(input logic [7:0] b[$], input string nm);
        int acc, nerr, sones, nbusy, ndone;
        nerr = 0; sones = 0; nbusy = 0; ndone = 0;
        send_bytes(b, 1'b1, acc);
        check_val({nm, "_accepted"}, acc, b.size());
        for (int k = 1; k <= 12; k++) begin
            if (k == 1) check_val({nm, "_error_pulse"}, {31'd0, err}, 32'd1);
            if (err === 1'b1) nerr++;
            if (serial !== 1'b0) sones++;
            if (busy !== 1'b0) nbusy++;
            if (done !== 1'b0) ndone++;
            @(negedge clk);
        end
        check_val({nm, "_error_count"}, nerr, 1);
        check_val({nm, "_serial_quiet"}, sones, 0);
        check_val({nm, "_busy_quiet"}, nbusy, 0);
        check_val({nm, "_no_done"}, ndone, 0);
        check_val({nm, "_csum_kept"}, csum, last_csum);
    endtask

    function automatic void rand_pkt(input int n, output logic [7:0] q[$]);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    endfunction

    initial begin
        logic [7:0] p42[$] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h0A, 8'hFF, 8'hFF, 8'hAB, 8'hCD};
        logic [7:0] p43[$] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h09, 8'h00, 8'h00, 8'hAB};
        logic [7:0] q[$];
        int acc, nev, n, r;

        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_serial", {31'd0, serial}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_error", {31'd0, err}, 32'd0);
        check_val("rst_csum", csum, 32'h0);
        check_val("rst_ready", {31'd0, bus.o_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        run_good(p42, "pkt42");
`ifdef UDP_TX_CSUM_EN
        check_val("pkt42_csum_const", csum, 32'hEB7B);
`else
        check_val("pkt42_csum_const", csum, 32'h0000);
`endif
        run_good(p43, "pkt43");
`ifdef UDP_TX_CSUM_EN
        check_val("pkt43_csum_const", csum, 32'hEC49);
`endif
        rand_pkt(5, q);
        run_drop(q, "short5");
        rand_pkt(20, q);
        run_drop(q, "over20");

        // Reset in the middle of byte 3 of a frame.
        send_bytes(p42, 1'b0, acc);
        for (int k = 1; k < 22; k++) @(negedge clk);
        check_val("midrst_pre_serial", {31'd0, serial}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_serial", {31'd0, serial}, 32'd0);
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        check_val("midrst_csum", csum, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_csum = 16'h0000;
        nev = 0;
        for (int k = 0; k < 30; k++) begin
            if (done !== 1'b0 || err !== 1'b0 || serial !== 1'b0) nev++;
            @(negedge clk);
        end
        check_val("midrst_quiet", nev, 0);
        run_good(p42, "after_rst");

        // Boundaries of the legal length range.
        rand_pkt(8, q);     run_good(q, "len8");
        rand_pkt(MAXB, q);  run_good(q, "len16");
        rand_pkt(7, q);     run_drop(q, "len7");
        rand_pkt(MAXB + 1, q); run_drop(q, "len17");

        // Random mix of legal, short and oversize packets.
        for (int t = 0; t < 25; t++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      n = $urandom_range(8, MAXB);
            else if (r < 8) n = $urandom_range(1, 7);
            else            n = $urandom_range(MAXB + 1, MAXB + 8);
            rand_pkt(n, q);
            if (n >= 8 && n <= MAXB) run_good(q, $sformatf("rnd%0d", t));
            else                     run_drop(q, $sformatf("rnd%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
